mem_access_unit: RTL and testbench

//  Memory-stage load/store engine: producer side of the MEM/WB register. Takes the

---
 rtl/mem_access_unit_pkg.sv | 51 +++++
 rtl/mem_access_unit_lane_align.sv | 64 ++++++
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_pkg
//  Purpose  : Shared types and constants for the memory-stage load/store
//             engine: data widths, opcode/funct3 encodings, FSM states and
//             an alignment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] instr_t;
   typedef logic [XLEN-1:0] data_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // size = funct3[1:0]; a size code of 2'b11 (doubleword) is not supported
   // on this 32-bit bus and is reported the same way as a misaligned access.
   function automatic logic is_aligned(input logic [1:0] size,
                                       input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      case (size)
         2'b00:   ok = 1'b1;
         2'b01:   ok = (off[0] == 1'b0);
         2'b10:   ok = (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Purely combinational byte-lane logic. Store side: byte enables
//             and lane-replicated write data. Load side: shifts the read word
//             down by the byte offset and sign/zero-extends.
//  Ports    : st_funct3/st_offset/st_data -> st_be, st_wdata
//             ld_funct3/ld_offset/ld_word -> ld_data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0] st_funct3,
   input  logic [1:0] st_offset,
   input  data_t      st_data,
   output logic [3:0] st_be,
   output data_t      st_wdata,
   input  logic [2:0] ld_funct3,
   input  logic [1:0] ld_offset,
   input  data_t      ld_word,
   output data_t      ld_data
);

   data_t w_shifted;
   logic  w_unused;

   // Bit 2 of a store funct3 carries no size information.
   assign w_unused = st_funct3[2];

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << st_offset;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

   assign w_shifted = ld_word >> {ld_offset, 3'b000};

   always_comb begin
      ld_data = w_shifted;
      case (ld_funct3)
         F3_LB:   ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_LH:   ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_LBU:  ld_data = {24'h0, w_shifted[7:0]};
         F3_LHU:  ld_data = {16'h0, w_shifted[15:0]};
         default: ld_data = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Memory-stage load/store engine. Decodes loads/stores from the
//             EX/MEM register, runs a req/ack bus transaction, aligns and
//             extends load data and stalls the pipe until the access is done.
//  Ports    : clk, rst (async, active-high), flush
//             valid_in, instr_in, addr_in, store_data_in   - from EX/MEM
//             bus_req, bus_we, bus_addr, bus_wdata, bus_be - bus request
//             bus_ack, bus_rdata                           - bus response
//             mem_data_out, mem_valid_out, fault_out       - to MEM/WB
//             stall_out                                    - pipeline hold
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT    = 256,
   parameter bit TIMEOUT_EN = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       valid_in,
   input  instr_t     instr_in,
   input  data_t      addr_in,
   input  data_t      store_data_in,
   output logic       bus_req,
   output logic       bus_we,
   output data_t      bus_addr,
   output data_t      bus_wdata,
   output logic [3:0] bus_be,
   input  logic       bus_ack,
   input  data_t      bus_rdata,
   output data_t      mem_data_out,
   output logic       mem_valid_out,
   output logic       fault_out,
   output logic       stall_out
);

   localparam int            CW         = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

   mem_state_t r_state;
   mem_state_t w_state_nxt;

   logic [CW-1:0] r_cnt;
   logic          r_kill;
   logic          r_fault;
   logic          r_bus_we;
   data_t         r_bus_addr;
   data_t         r_bus_wdata;
   logic [3:0]    r_bus_be;
   logic [2:0]    r_funct3;
   logic [1:0]    r_offset;
   data_t         r_mem_data;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_is_load;
   logic       w_is_store;
   logic       w_start;
   logic       w_aligned;
   logic       w_go;
   logic       w_misalign;
   logic       w_timeout;
   logic [3:0] w_st_be;
   data_t      w_st_wdata;
   data_t      w_ld_data;
   logic       w_unused;

   assign w_opcode   = instr_in[6:0];
   assign w_funct3   = instr_in[14:12];
   assign w_is_load  = (w_opcode == OPC_LOAD);
   assign w_is_store = (w_opcode == OPC_STORE);
   assign w_start    = valid_in & ~flush & (w_is_load | w_is_store);
   assign w_aligned  = is_aligned(w_funct3[1:0], addr_in[1:0]);
   assign w_go       = w_start & w_aligned;
   assign w_misalign = w_start & ~w_aligned;
   assign w_timeout  = (TIMEOUT_EN != 1'b0) && (r_cnt == c_cnt_last);

   // Register/immediate fields are irrelevant to the memory stage.
   assign w_unused = &{1'b0, instr_in[31:15], instr_in[11:7]};

   // Store lanes are computed from the live inputs and latched on entry to
   // BUSY; load extraction uses the latched funct3/offset with the bus word.
   mem_lane_align u_lane_align (
      .st_funct3 (w_funct3),
      .st_offset (addr_in[1:0]),
      .st_data   (store_data_in),
      .st_be     (w_st_be),
      .st_wdata  (w_st_wdata),
      .ld_funct3 (r_funct3),
      .ld_offset (r_offset),
      .ld_word   (bus_rdata),
      .ld_data   (w_ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_go) begin
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            // An ack in the final timeout cycle still completes the access.
            if (bus_ack) begin
               w_state_nxt = DONE;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_kill      <= 1'b0;
         r_fault     <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_be    <= 4'b0000;
         r_funct3    <= 3'b000;
         r_offset    <= 2'b00;
         r_mem_data  <= '0;
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  r_bus_addr  <= {addr_in[XLEN-1:2], 2'b00};
                  r_bus_be    <= w_st_be;
                  r_bus_wdata <= w_st_wdata;
                  r_bus_we    <= w_is_store;
                  r_funct3    <= w_funct3;
                  r_offset    <= addr_in[1:0];
                  r_cnt       <= '0;
                  r_kill      <= 1'b0;
               end else if (w_misalign) begin
                  r_fault <= 1'b1;
               end
            end
            BUSY: begin
               // A flush cannot abort the handshake; it only marks the
               // result as discarded.
               if (flush) begin
                  r_kill <= 1'b1;
               end
               if (bus_ack) begin
                  r_mem_data <= r_bus_we ? '0 : w_ld_data;
               end else if (w_timeout) begin
                  r_mem_data <= '0;
                  r_fault    <= ~(r_kill | flush);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus_req       = (r_state == BUSY);
   assign bus_we        = r_bus_we;
   assign bus_addr      = r_bus_addr;
   assign bus_wdata     = r_bus_wdata;
   assign bus_be        = r_bus_be;
   assign mem_data_out  = r_mem_data;
   assign mem_valid_out = (r_state == DONE) & ~r_kill & ~flush;
   assign fault_out     = r_fault;
   assign stall_out     = ((r_state == IDLE) & w_go) | (r_state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit (TIMEOUT=8).
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       valid_in;
   instr_t     instr_in;
   data_t      addr_in;
   data_t      store_data_in;
   logic       bus_req;
   logic       bus_we;
   data_t      bus_addr;
   data_t      bus_wdata;
   logic [3:0] bus_be;
   logic       bus_ack;
   data_t      bus_rdata;
   data_t      mem_data_out;
   logic       mem_valid_out;
   logic       fault_out;
   logic       stall_out;

   always #5 clk = ~clk;

   mem_access_unit #(
      .TIMEOUT    (8),
      .TIMEOUT_EN (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .valid_in      (valid_in),
      .instr_in      (instr_in),
      .addr_in       (addr_in),
      .store_data_in (store_data_in),
      .bus_req       (bus_req),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_be        (bus_be),
      .bus_ack       (bus_ack),
      .bus_rdata     (bus_rdata),
      .mem_data_out  (mem_data_out),
      .mem_valid_out (mem_valid_out),
      .fault_out     (fault_out),
      .stall_out     (stall_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic instr_t mk(input logic [2:0] f3, input logic [6:0] opc);
      return {17'h0, f3, 5'h0, opc};
   endfunction

   // Per-access observations
   int         stall_cyc, req_cyc, valid_cnt, fault_cnt, unstable;
   data_t      last_data, cap_addr, cap_wdata;
   logic [3:0] cap_be;
   logic       cap_we, seen_req;

   // Presents one instruction for a single cycle, acks on the ack_after-th
   // request cycle (0 = never), optionally flushes in cycle flush_at.
   task automatic run_access(input instr_t ins, input data_t addr, input data_t sd,
                             input int ack_after, input data_t rdata,
                             input int flush_at, input int ncyc);
      stall_cyc = 0; req_cyc = 0; valid_cnt = 0; fault_cnt = 0; unstable = 0;
      last_data = 32'hxxxx_xxxx; seen_req = 1'b0;
      cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         valid_in      = (c == 0);
         instr_in      = ins;
         addr_in       = addr;
         store_data_in = sd;
         flush         = (c == flush_at);
         if (bus_req) begin
            req_cyc++;
            if (!seen_req) begin
               seen_req  = 1'b1;
               cap_addr  = bus_addr;
               cap_wdata = bus_wdata;
               cap_be    = bus_be;
               cap_we    = bus_we;
            end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata ||
                         bus_be !== cap_be || bus_we !== cap_we) begin
               unstable++;
            end
         end
         bus_ack   = bus_req && (req_cyc == ack_after);
         bus_rdata = bus_ack ? rdata : 32'h0;
         #1;
         if (stall_out)     stall_cyc++;
         if (mem_valid_out) begin valid_cnt++; last_data = mem_data_out; end
         if (fault_out)     fault_cnt++;
      end
      @(posedge clk); #1;
      valid_in = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; valid_in = 1'b0; instr_in = '0; addr_in = '0;
      store_data_in = '0; bus_ack = 1'b0; bus_rdata = '0;
      @(posedge clk); #1;
      check("reset_ctrl", {27'h0, bus_req, bus_we, mem_valid_out, fault_out, stall_out}, 32'h0);
      check("reset_addr",  bus_addr,     32'h0);
      check("reset_wdata", bus_wdata,    32'h0);
      check("reset_be",    {28'h0, bus_be}, 32'h0);
      check("reset_mdata", mem_data_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // LB @0x1003, ack on third request cycle
      run_access(mk(F3_LB, OPC_LOAD), 32'h1003, 32'h0, 3, 32'h80FF_FF12, -1, 8);
      check("lb_stall",  stall_cyc, 4);
      check("lb_req",    req_cyc,   3);
      check("lb_valid",  valid_cnt, 1);
      check("lb_data",   last_data, 32'hFFFF_FF80);
      check("lb_addr",   cap_addr,  32'h0000_1000);
      check("lb_we",     {31'h0, cap_we}, 32'h0);
      check("lb_fault",  fault_cnt, 0);

      run_access(mk(F3_LBU, OPC_LOAD), 32'h1003, 32'h0, 3, 32'h80FF_FF12, -1, 8);
      check("lbu_data",  last_data, 32'h0000_0080);

      run_access(mk(F3_LHU, OPC_LOAD), 32'h1002, 32'h0, 1, 32'h80FF_FF12, -1, 5);
      check("lhu_data",  last_data, 32'h0000_80FF);
      check("lhu_stall", stall_cyc, 2);

      run_access(mk(F3_LH, OPC_LOAD), 32'h1002, 32'h0, 1, 32'h80FF_FF12, -1, 5);
      check("lh_data",   last_data, 32'hFFFF_80FF);

      // SH @0x2002
      run_access(mk(F3_SH, OPC_STORE), 32'h2002, 32'h1234_ABCD, 2, 32'h0, -1, 6);
      check("sh_be",     {28'h0, cap_be}, 32'h0000_000C);
      check("sh_wdata",  cap_wdata, 32'hABCD_ABCD);
      check("sh_we",     {31'h0, cap_we}, 32'h1);
      check("sh_addr",   cap_addr,  32'h0000_2000);
      check("sh_valid",  valid_cnt, 1);
      check("sh_mdata",  last_data, 32'h0);
      check("sh_stable", unstable,  0);

      run_access(mk(F3_SB, OPC_STORE), 32'h2001, 32'h0000_0055, 1, 32'h0, -1, 5);
      check("sb_be",     {28'h0, cap_be}, 32'h0000_0002);
      check("sb_wdata",  cap_wdata, 32'h5555_5555);

      run_access(mk(F3_SW, OPC_STORE), 32'h2004, 32'hCAFE_F00D, 1, 32'h0, -1, 5);
      check("sw_be",     {28'h0, cap_be}, 32'h0000_000F);
      check("sw_wdata",  cap_wdata, 32'hCAFE_F00D);

      // Misaligned LW
      run_access(mk(F3_LW, OPC_LOAD), 32'h1001, 32'h0, 1, 32'h0, -1, 5);
      check("mis_req",   req_cyc,   0);
      check("mis_fault", fault_cnt, 1);
      check("mis_stall", stall_cyc, 0);
      check("mis_valid", valid_cnt, 0);

      // Non-memory instruction (R-type)
      run_access(mk(3'b000, 7'b0110011), 32'h1001, 32'h0, 1, 32'h0, -1, 4);
      check("alu_act", {stall_cyc[7:0], req_cyc[7:0], fault_cnt[7:0], valid_cnt[7:0]}, 32'h0);

      // Timeout with no ack
      run_access(mk(F3_LW, OPC_LOAD), 32'h1000, 32'h0, 0, 32'h0, -1, 14);
      check("to_req",    req_cyc,   8);
      check("to_fault",  fault_cnt, 1);
      check("to_stall",  stall_cyc, 9);
      check("to_valid",  valid_cnt, 0);
      check("to_mdata",  mem_data_out, 32'h0);
      check("to_idle",   {30'h0, bus_req, stall_out}, 32'h0);

      // Flush one cycle into BUSY, ack two cycles later
      run_access(mk(F3_LW, OPC_LOAD), 32'h1000, 32'h0, 3, 32'h1111_2222, 1, 8);
      check("fl_req",    req_cyc,   3);
      check("fl_valid",  valid_cnt, 0);
      check("fl_fault",  fault_cnt, 0);

      // Asynchronous reset mid-BUSY
      @(posedge clk); #1;
      valid_in = 1'b1; instr_in = mk(F3_LW, OPC_LOAD); addr_in = 32'h3000;
      @(posedge clk); #1;
      valid_in = 1'b0;
      check("rst_pre_req", {31'h0, bus_req}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_req",   {31'h0, bus_req},   32'h0);
      check("rst_stall", {31'h0, stall_out}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_access(mk(F3_LW, OPC_LOAD), 32'h3000, 32'h0, 1, 32'hDEAD_BEEF, -1, 5);
      check("post_rst_data",  last_data, 32'hDEAD_BEEF);
      check("post_rst_stall", stall_cyc, 2);
      check("post_rst_valid", valid_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
